// File: rtl/adder_share_arb.sv
// Round-robin arbiter sharing one 16-bit Ladner-Fischer adder among NREQ lanes.
// Two-stage pipeline: operand register, then adder into a result register.
module add (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [15:0] sum_o
);

  logic [15:0] g, p, gn, pn;
  int j;

  always_comb begin
    g  = a_i & b_i;
    p  = a_i ^ b_i;
    gn = g;
    pn = p;
    j  = 0;
    // Each level merges a bit with the top of the previous aligned block
    for (int l = 0; l < 4; l++) begin
      gn = g;
      pn = p;
      for (int i = 0; i < 16; i++) begin
        if (((i >> l) & 1) != 0) begin
          j = ((i >> l) << l) - 1;
          gn[i] = g[i] | (p[i] & g[j[3:0]]);
          pn[i] = p[i] & p[j[3:0]];
        end
      end
      g = gn;
      p = pn;
    end
    sum_o = (a_i ^ b_i) ^ {g[14:0], 1'b0};
  end

endmodule

module adder_share_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*16-1:0] req_a,
  input  logic [NREQ*16-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [15:0]       rsp_sum,
  output logic              busy,
  output logic [15:0]       op_count
);

  logic            s1_valid_q;
  logic [15:0]     s1_a_q, s1_b_q;
  logic [IDW-1:0]  s1_id_q;
  logic            rsp_valid_q;
  logic [15:0]     rsp_sum_q;
  logic [IDW-1:0]  rsp_id_q;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [15:0]     cnt_q, cnt_d;

  logic              adv1, adv2, hit, acc;
  logic [IDW-1:0]    gnt;
  logic [IDW:0]      wsum;
  logic [2*NREQ-1:0] dbl;
  logic [15:0]       sel_a, sel_b, add_s;

  assign adv2 = !rsp_valid_q | rsp_ready;
  assign adv1 = !s1_valid_q | adv2;

  // Rotate so the scan starts at ptr; offset is mapped back with wrap
  always_comb begin
    dbl  = {req_valid, req_valid} >> ptr_q;
    hit  = 1'b0;
    wsum = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!hit && dbl[k]) begin
        hit  = 1'b1;
        wsum = {1'b0, ptr_q} + (IDW+1)'(k);
      end
    end
    if (wsum >= (IDW+1)'(NREQ))
      wsum = wsum - (IDW+1)'(NREQ);
    gnt = wsum[IDW-1:0];
  end

  assign acc = hit & adv1;

  always_comb begin
    req_ready = '0;
    sel_a     = '0;
    sel_b     = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (gnt == IDW'(k)) begin
        req_ready[k] = acc & rst_n;
        sel_a        = req_a[16*k +: 16];
        sel_b        = req_b[16*k +: 16];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (acc) begin
      ptr_d = (gnt == IDW'(NREQ-1)) ? '0 : gnt + 1'b1;
      if (cnt_q != 16'hFFFF)
        cnt_d = cnt_q + 16'd1;
    end
  end

  add u_add (
    .a_i   (s1_a_q),
    .b_i   (s1_b_q),
    .sum_o (add_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_id_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_id_q    <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      if (adv2) begin
        rsp_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          rsp_sum_q <= add_s;
          rsp_id_q  <= s1_id_q;
        end
      end
      if (acc) begin
        s1_valid_q <= 1'b1;
        s1_a_q     <= sel_a;
        s1_b_q     <= sel_b;
        s1_id_q    <= gnt;
      end else if (adv1) begin
        s1_valid_q <= 1'b0;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = s1_valid_q | rsp_valid_q;
  assign op_count  = cnt_q;

endmodule
